// File: rtl/seq_frame_tx.sv
`default_nettype none
// ============================================================================
// seq_frame_tx : serial frame transmitter (preamble, MSB-first data, even
//                parity, idle guard bits) feeding the "011" detector link.
// Revision 1.0
// ============================================================================
module seq_frame_tx #(
  parameter int                 DATA_W    = 8,
  parameter int                 PRE_LEN   = 3,
  parameter logic [PRE_LEN-1:0] PREAMBLE  = 3'b011,
  parameter int                 PARITY_EN = 1,
  parameter int                 GAP_LEN   = 2,
  parameter logic               IDLE_BIT  = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              dout,
  output logic              busy,
  output logic              frame_done
);

  localparam int MAX_LEN_PD = (PRE_LEN > DATA_W) ? PRE_LEN : DATA_W;
  localparam int MAX_LEN    = (MAX_LEN_PD > GAP_LEN) ? MAX_LEN_PD : GAP_LEN;
  localparam int CNT_W      = $clog2(MAX_LEN + 1);
  localparam int SR_W       = PRE_LEN + DATA_W;

  localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PRE_LEN - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_LEN - 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_DATA = 3'd2,
    ST_PAR  = 3'd3,
    ST_GAP  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SR_W-1:0]   sreg_q, sreg_d;
  logic              par_q, par_d;
  logic              dout_q, dout_d;
  logic              frame_done_q, frame_done_d;
  logic              w_ready;
  logic              w_accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      sreg_q       <= '0;
      par_q        <= 1'b0;
      dout_q       <= IDLE_BIT;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sreg_q       <= sreg_d;
      par_q        <= par_d;
      dout_q       <= dout_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    sreg_d       = sreg_q;
    par_d        = par_q;
    dout_d       = IDLE_BIT;
    frame_done_d = 1'b0;

    w_ready  = (state_q == ST_IDLE) || ((state_q == ST_GAP) && (cnt_q == GAP_LAST));
    w_accept = tx_valid & w_ready;

    // Counter holds the index, within the current segment, of the bit now on dout.
    case (state_q)
      ST_IDLE: ;
      ST_PRE: begin
        dout_d = sreg_q[SR_W-1];
        sreg_d = sreg_q << 1;
        if (cnt_q == PRE_LAST) begin
          state_d = ST_DATA;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (cnt_q != DATA_LAST) begin
          dout_d = sreg_q[SR_W-1];
          sreg_d = sreg_q << 1;
          cnt_d  = cnt_q + CNT_W'(1);
        end else if (PARITY_EN != 0) begin
          state_d = ST_PAR;
          dout_d  = par_q;
        end else begin
          state_d = ST_GAP;
          cnt_d   = '0;
        end
      end
      ST_PAR: begin
        state_d = ST_GAP;
        cnt_d   = '0;
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Accept is only possible in IDLE or the final GAP cycle, so it overrides both.
    if (w_accept) begin
      state_d = ST_PRE;
      cnt_d   = '0;
      sreg_d  = {PREAMBLE, tx_data} << 1;
      par_d   = ^tx_data;
      dout_d  = PREAMBLE[PRE_LEN-1];
    end

    frame_done_d = (state_d == ST_PAR) ||
                   ((PARITY_EN == 0) && (state_d == ST_DATA) && (cnt_d == DATA_LAST));
  end

  assign tx_ready   = w_ready & ~rst;
  assign dout       = dout_q;
  assign busy       = (state_q != ST_IDLE);
  assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_frame_tx.sv
`default_nettype none
// ============================================================================
// tb_seq_frame_tx : scoreboard bench for seq_frame_tx (default config plus a
//                   no-parity, single-gap config).
// Revision 1.0
// ============================================================================
module tb_seq_frame_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data, tx_data2;
  logic       tx_valid, tx_valid2;
  logic       tx_ready, dout, busy, frame_done;
  logic       tx_ready2, dout2, busy2, frame_done2;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic dout;
    logic fd;
    logic rdy;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  seq_frame_tx dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .dout(dout), .busy(busy), .frame_done(frame_done)
  );

  seq_frame_tx #(.PARITY_EN(0), .GAP_LEN(1)) dut2 (
    .clk(clk), .rst(rst), .tx_data(tx_data2), .tx_valid(tx_valid2),
    .tx_ready(tx_ready2), .dout(dout2), .busy(busy2), .frame_done(frame_done2)
  );

  // Expected serial stream: preamble 011, data MSB first, optional even parity, gap.
  function automatic void push_frame(input logic [7:0] d, input bit par_en, input int gap);
    logic [11:0] bits;
    int          nb;
    bits = {3'b011, d, ^d};
    nb   = par_en ? 12 : 11;
    for (int i = 0; i < nb; i++)
      sb_q.push_back(exp_t'{bits[11-i], (i == nb - 1), 1'b0});
    for (int g = 0; g < gap; g++)
      sb_q.push_back(exp_t'{1'b1, 1'b0, (g == gap - 1)});
  endfunction

  task automatic test_reset();
    rst = 1'b1; tx_valid = 1'b1; tx_data = 8'hFF; tx_valid2 = 1'b1; tx_data2 = 8'h00;
    repeat (3) @(negedge clk);
    n_checks++; if (dout !== 1'b1) begin n_fail++; $display("FAIL reset_dout: got %b exp 1", dout); end
    n_checks++; if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b exp 0", tx_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b exp 0", busy); end
    n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_fd: got %b exp 0", frame_done); end
    n_checks++; if (tx_ready2 !== 1'b0 || dout2 !== 1'b1 || busy2 !== 1'b0) begin
      n_fail++; $display("FAIL reset_dut2: got rdy=%b dout=%b busy=%b exp 0 1 0", tx_ready2, dout2, busy2);
    end
    rst = 1'b0; tx_valid = 1'b0; tx_valid2 = 1'b0;
    @(negedge clk);
    n_checks++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b exp 1", tx_ready); end
    n_checks++; if (tx_ready2 !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready2: got %b exp 1", tx_ready2); end
  endtask

  task automatic test_single_frame();
    n_checks++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready_pre: got %b exp 1", tx_ready); end
    tx_valid = 1'b1; tx_data = 8'hA5;
    push_frame(8'hA5, 1'b1, 2);
    @(negedge clk);
    tx_valid = 1'b0; tx_data = 8'h00;
    for (int i = 0; i < 14; i++) begin
      exp_t e;
      e = sb_q.pop_front();
      n_checks++; if (dout !== e.dout) begin n_fail++; $display("FAIL single_dout[%0d]: got %b exp %b", i, dout, e.dout); end
      n_checks++; if (frame_done !== e.fd) begin n_fail++; $display("FAIL single_fd[%0d]: got %b exp %b", i, frame_done, e.fd); end
      n_checks++; if (tx_ready !== e.rdy) begin n_fail++; $display("FAIL single_ready[%0d]: got %b exp %b", i, tx_ready, e.rdy); end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    tx_valid = 1'b1; tx_data = 8'hFF;
    push_frame(8'hFF, 1'b1, 2);
    @(negedge clk);
    for (int i = 0; i < 28; i++) begin
      exp_t e;
      e = sb_q.pop_front();
      n_checks++; if (dout !== e.dout) begin n_fail++; $display("FAIL b2b_dout[%0d]: got %b exp %b", i, dout, e.dout); end
      n_checks++; if (frame_done !== e.fd) begin n_fail++; $display("FAIL b2b_fd[%0d]: got %b exp %b", i, frame_done, e.fd); end
      n_checks++; if (tx_ready !== e.rdy) begin n_fail++; $display("FAIL b2b_ready[%0d]: got %b exp %b", i, tx_ready, e.rdy); end
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy[%0d]: got %b exp 1", i, busy); end
      if (i == 3) tx_data = 8'h5A;
      if (i == 13) begin
        tx_data = 8'h00;
        push_frame(8'h00, 1'b1, 2);
      end
      if (i == 18) begin
        tx_data = 8'hC3; tx_valid = 1'b0;
      end
      @(negedge clk);
    end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_busy: got %b exp 0", busy); end
  endtask

  task automatic test_no_parity();
    n_checks++; if (tx_ready2 !== 1'b1) begin n_fail++; $display("FAIL nopar_ready_pre: got %b exp 1", tx_ready2); end
    tx_valid2 = 1'b1; tx_data2 = 8'h01;
    push_frame(8'h01, 1'b0, 1);
    @(negedge clk);
    tx_valid2 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      exp_t e;
      e = sb_q.pop_front();
      n_checks++; if (dout2 !== e.dout) begin n_fail++; $display("FAIL nopar_dout[%0d]: got %b exp %b", i, dout2, e.dout); end
      n_checks++; if (frame_done2 !== e.fd) begin n_fail++; $display("FAIL nopar_fd[%0d]: got %b exp %b", i, frame_done2, e.fd); end
      n_checks++; if (tx_ready2 !== e.rdy) begin n_fail++; $display("FAIL nopar_ready[%0d]: got %b exp %b", i, tx_ready2, e.rdy); end
      @(negedge clk);
    end
    n_checks++; if (busy2 !== 1'b0) begin n_fail++; $display("FAIL nopar_idle_busy: got %b exp 0", busy2); end
  endtask

  task automatic test_reset_mid_frame();
    tx_valid = 1'b1; tx_data = 8'h96;
    push_frame(8'h96, 1'b1, 2);
    @(negedge clk);
    tx_valid = 1'b0;
    // Frame index 6 is data bit 3; reset lands on the edge after it.
    for (int i = 0; i < 7; i++) begin
      exp_t e;
      e = sb_q.pop_front();
      n_checks++; if (dout !== e.dout) begin n_fail++; $display("FAIL midrst_dout[%0d]: got %b exp %b", i, dout, e.dout); end
      n_checks++; if (frame_done !== e.fd) begin n_fail++; $display("FAIL midrst_fd[%0d]: got %b exp %b", i, frame_done, e.fd); end
      if (i < 6) @(negedge clk);
    end
    sb_q.delete();
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (dout !== 1'b1) begin n_fail++; $display("FAIL midrst_abort_dout: got %b exp 1", dout); end
    n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL midrst_abort_fd: got %b exp 0", frame_done); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_abort_busy: got %b exp 0", busy); end
    n_checks++; if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_abort_ready: got %b exp 0", tx_ready); end
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (tx_ready !== 1'b1 || dout !== 1'b1 || frame_done !== 1'b0) begin
      n_fail++; $display("FAIL midrst_release: got rdy=%b dout=%b fd=%b exp 1 1 0", tx_ready, dout, frame_done);
    end
    tx_valid = 1'b1; tx_data = 8'h3C;
    push_frame(8'h3C, 1'b1, 2);
    @(negedge clk);
    tx_valid = 1'b0;
    for (int i = 0; i < 14; i++) begin
      exp_t e;
      e = sb_q.pop_front();
      n_checks++; if (dout !== e.dout) begin n_fail++; $display("FAIL midrst_3c_dout[%0d]: got %b exp %b", i, dout, e.dout); end
      n_checks++; if (frame_done !== e.fd) begin n_fail++; $display("FAIL midrst_3c_fd[%0d]: got %b exp %b", i, frame_done, e.fd); end
      n_checks++; if (tx_ready !== e.rdy) begin n_fail++; $display("FAIL midrst_3c_ready[%0d]: got %b exp %b", i, tx_ready, e.rdy); end
      @(negedge clk);
    end
  endtask

  task automatic test_loopback();
    logic [1:0] hist;
    int         pre_hits;
    int         data_hits;
    hist = 2'b11; pre_hits = 0; data_hits = 0;
    tx_valid = 1'b1; tx_data = 8'h36;
    push_frame(8'h36, 1'b1, 2);
    @(negedge clk);
    tx_valid = 1'b0;
    for (int i = 0; i < 14; i++) begin
      exp_t e;
      e = sb_q.pop_front();
      n_checks++; if (dout !== e.dout) begin n_fail++; $display("FAIL loop_dout[%0d]: got %b exp %b", i, dout, e.dout); end
      // Mealy 011 detector watching the link, counted over the frame bits only.
      if (i < 12 && hist == 2'b01 && dout == 1'b1) begin
        if (i == 2) pre_hits++;
        else if (i >= 3 && i < 11) data_hits++;
      end
      hist = {hist[0], dout};
      @(negedge clk);
    end
    n_checks++; if (pre_hits != 1) begin n_fail++; $display("FAIL loop_pre_hits: got %0d exp 1", pre_hits); end
    n_checks++; if (data_hits != 2) begin n_fail++; $display("FAIL loop_data_hits: got %0d exp 2", data_hits); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; tx_valid = 1'b0; tx_data = 8'h00; tx_valid2 = 1'b0; tx_data2 = 8'h00;
    @(negedge clk);
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_no_parity();
    test_reset_mid_frame();
    test_loopback();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
